// File: rtl/mc_pkg.sv
// Shared state encoding and default opcode / ALU constants for the multicycle sequencer.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam int DEF_OP_W      = 4;
    localparam int DEF_ALUOP_W   = 4;
    localparam int DEF_OP_LOAD   = 'h6;
    localparam int DEF_OP_STORE  = 'h7;
    localparam int DEF_OP_BRANCH = 'h8;
    localparam int DEF_OP_HALT   = 'hF;
    localparam int DEF_ALU_ADD   = 0;
    localparam int DEF_ALU_SUB   = 1;
    localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/mc_perf_counters.sv
// Saturating performance counters (cycles, retired instructions, memory stalls).
// Only instantiated when MC_SEQ_PERF_EN is defined.
module mc_perf_counters #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             retire_i,
    input  logic             stall_i,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        cycle_d = sat_inc(cycle_q, 1'b1);
        instr_d = sat_inc(instr_q, retire_i);
        stall_d = sat_inc(stall_q, stall_i);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cycle_q <= '0;
            instr_q <= '0;
            stall_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
            stall_q <= stall_d;
        end
    end

    assign cycle_cnt_o = cycle_q;
    assign instr_cnt_o = instr_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle CPU control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT FSM driving datapath enables.
// Define MC_SEQ_PERF_EN to build the saturating perf counters; otherwise they read constant 0.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int OP_W      = DEF_OP_W,
    parameter int ALUOP_W   = DEF_ALUOP_W,
    parameter int OP_LOAD   = DEF_OP_LOAD,
    parameter int OP_STORE  = DEF_OP_STORE,
    parameter int OP_BRANCH = DEF_OP_BRANCH,
    parameter int OP_HALT   = DEF_OP_HALT,
    parameter int ALU_ADD   = DEF_ALU_ADD,
    parameter int ALU_SUB   = DEF_ALU_SUB,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    input  logic               alu_zero,
    input  logic               resume,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCSrc,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [ALUOP_W-1:0] ALUop,
    output logic [2:0]         state,
    output logic               halted,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   instr_cnt,
    output logic [CNT_W-1:0]   stall_cnt
);

    state_e state_q, state_d;
    logic   is_load, is_store, is_branch, is_halt;

    assign is_load   = (opcode == OP_W'(OP_LOAD));
    assign is_store  = (opcode == OP_W'(OP_STORE));
    assign is_branch = (opcode == OP_W'(OP_BRANCH));
    assign is_halt   = (opcode == OP_W'(OP_HALT));

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Reset dominates: while it is high no datapath enable may fire, even from FETCH.
    always_comb begin
        state_d  = state_q;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUop    = '0;
        halted   = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUop   = ALUOP_W'(ALU_ADD);
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: state_d = is_halt ? S_HALT : S_EXEC;
                S_EXEC: begin
                    if (is_branch) begin
                        ALUop   = ALUOP_W'(ALU_SUB);
                        PCSrc   = 1'b1;
                        PCWrite = alu_zero;
                        state_d = S_FETCH;
                    end else begin
                        ALUop   = ALUOP_W'(opcode);
                        state_d = (is_load || is_store) ? S_MEM : S_WB;
                    end
                end
                S_MEM: begin
                    MemRead  = is_load;
                    MemWrite = is_store;
                    if (mem_ready) state_d = is_load ? S_WB : S_FETCH;
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    state_d  = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                    if (resume) state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign state = state_q;

`ifdef MC_SEQ_PERF_EN
    logic retire, stall;

    assign retire = (state_q == S_WB) ||
                    ((state_q == S_EXEC) && is_branch) ||
                    ((state_q == S_MEM) && is_store && mem_ready);
    assign stall  = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;

    mc_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk_i       (clk),
        .reset_i     (reset),
        .retire_i    (retire),
        .stall_i     (stall),
        .cycle_cnt_o (cycle_cnt),
        .instr_cnt_o (instr_cnt),
        .stall_cnt_o (stall_cnt)
    );
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: per-instruction reference model feeds an
// expected-output queue that a negedge monitor drains and compares.
module tb_mc_sequencer;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_LOAD   = 4'h6;
    localparam logic [3:0] OP_STORE  = 4'h7;
    localparam logic [3:0] OP_BRANCH = 4'h8;
    localparam logic [3:0] OP_HALT   = 4'hF;
    localparam int         W         = 62;

    // {IRWrite, PCWrite, PCSrc, RegWrite, MemRead, MemWrite}
    localparam logic [5:0] EN_NONE  = 6'b000000;
    localparam logic [5:0] EN_MRD   = 6'b000010;
    localparam logic [5:0] EN_MWR   = 6'b000001;
    localparam logic [5:0] EN_FETCH = 6'b110010;
    localparam logic [5:0] EN_WB    = 6'b000100;

    logic        clk;
    logic        reset;
    logic [3:0]  opcode;
    logic        mem_ready;
    logic        alu_zero;
    logic        resume;
    logic        IRWrite, PCWrite, PCSrc, RegWrite, MemRead, MemWrite;
    logic [3:0]  ALUop;
    logic [2:0]  state;
    logic        halted;
    logic [15:0] cycle_cnt, instr_cnt, stall_cnt;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int m_cyc = 0;
    int m_ins = 0;
    int m_stl = 0;

    mc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .alu_zero  (alu_zero),
        .resume    (resume),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .PCSrc     (PCSrc),
        .RegWrite  (RegWrite),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ALUop     (ALUop),
        .state     (state),
        .halted    (halted),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt),
        .stall_cnt (stall_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [47:0] exp_perf();
`ifdef MC_SEQ_PERF_EN
        return {16'(m_cyc), 16'(m_ins), 16'(m_stl)};
`else
        return 48'd0;
`endif
    endfunction

    function automatic void model_tick(input logic rst, input logic stl, input logic ret);
        if (rst) begin
            m_cyc = 0;
            m_ins = 0;
            m_stl = 0;
        end else begin
            if (m_cyc < 65535) m_cyc++;
            if (ret && m_ins < 65535) m_ins++;
            if (stl && m_stl < 65535) m_stl++;
        end
    endfunction

    // One clock cycle: drive inputs, queue the expected outputs, advance.
    task automatic step(input logic rst, input logic [3:0] op, input logic mr, input logic az,
                        input logic rs, input logic [2:0] st, input logic [5:0] en,
                        input logic [3:0] aop, input logic hlt, input logic stl, input logic ret);
        reset     = rst;
        opcode    = op;
        mem_ready = mr;
        alu_zero  = az;
        resume    = rs;
        exp_q.push_back({st, hlt, en, aop, exp_perf()});
        @(posedge clk);
        #1;
        model_tick(rst, stl, ret);
    endtask

    // Reference model of one instruction, from fetch to retire (or to leaving HALT).
    task automatic run_instr(input logic [3:0] op, input int fw, input int mw,
                             input logic az, input int hl);
        logic ld, sto, br;
        ld  = (op == OP_LOAD);
        sto = (op == OP_STORE);
        br  = (op == OP_BRANCH);
        for (int i = 0; i < fw; i++)
            step(1'b0, rop(), 1'b0, rb(), rb(), 3'd0, EN_MRD, 4'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, rop(), 1'b1, rb(), rb(), 3'd0, EN_FETCH, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, op, rb(), rb(), rb(), 3'd1, EN_NONE, 4'd0, 1'b0, 1'b0, 1'b0);
        if (op == OP_HALT) begin
            for (int i = 0; i < hl; i++)
                step(1'b0, op, rb(), rb(), 1'b0, 3'd5, EN_NONE, 4'd0, 1'b1, 1'b0, 1'b0);
            step(1'b0, op, rb(), rb(), 1'b1, 3'd5, EN_NONE, 4'd0, 1'b1, 1'b0, 1'b0);
            return;
        end
        if (br)
            step(1'b0, op, rb(), az, rb(), 3'd2, {1'b0, az, 1'b1, 3'b000}, 4'd1, 1'b0, 1'b0, 1'b1);
        else
            step(1'b0, op, rb(), rb(), rb(), 3'd2, EN_NONE, op, 1'b0, 1'b0, 1'b0);
        if (ld || sto) begin
            for (int i = 0; i < mw; i++)
                step(1'b0, op, 1'b0, rb(), rb(), 3'd3, ld ? EN_MRD : EN_MWR, 4'd0, 1'b0, 1'b1, 1'b0);
            step(1'b0, op, 1'b1, rb(), rb(), 3'd3, ld ? EN_MRD : EN_MWR, 4'd0, 1'b0, 1'b0, sto);
        end
        if (!br && !sto)
            step(1'b0, op, rb(), rb(), rb(), 3'd4, EN_WB, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // Scoreboard monitor
    initial begin
        logic [W-1:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {state, halted, IRWrite, PCWrite, PCSrc, RegWrite, MemRead, MemWrite,
                     ALUop, cycle_cnt, instr_cnt, stall_cnt};
                checks++;
                if (a[61:58] !== e[61:58]) begin
                    errors++;
                    $display("FAIL state/halted t=%0t got=%h exp=%h", $time, a[61:58], e[61:58]);
                end
                checks++;
                if (a[57:48] !== e[57:48]) begin
                    errors++;
                    $display("FAIL ctrl{IR,PC,PCSrc,Reg,MRd,MWr,ALUop} t=%0t got=%b exp=%b",
                             $time, a[57:48], e[57:48]);
                end
                checks++;
                if (a[47:0] !== e[47:0]) begin
                    errors++;
                    $display("FAIL perf{cyc,ins,stl} t=%0t got=%h exp=%h", $time, a[47:0], e[47:0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        reset = 1'b1; opcode = '0; mem_ready = 1'b0; alu_zero = 1'b0; resume = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, rop(), 1'b1, rb(), rb(), 3'd0, EN_NONE, 4'd0, 1'b0, 1'b0, 1'b0);

        run_instr(OP_ADD, 0, 0, 1'b0, 0);
        run_instr(OP_LOAD, 0, 3, 1'b0, 0);
        run_instr(OP_STORE, 0, 0, 1'b0, 0);
        run_instr(OP_BRANCH, 0, 0, 1'b1, 0);
        run_instr(OP_BRANCH, 1, 0, 1'b0, 0);
        run_instr(OP_HALT, 0, 0, 1'b0, 10);
        run_instr(4'h3, 2, 0, 1'b0, 0);

        for (int n = 0; n < 150; n++) begin
            logic [3:0] op;
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    op = OP_LOAD;
                2, 3:    op = OP_STORE;
                4, 5:    op = OP_BRANCH;
                6:       op = OP_HALT;
                default: op = rop();
            endcase
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rb(), $urandom_range(0, 4));
        end

        // Reset while a store sits in MEM with MemWrite asserted
        run_instr(OP_ADD, 0, 0, 1'b0, 0);
        step(1'b0, rop(), 1'b1, rb(), rb(), 3'd0, EN_FETCH, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, OP_STORE, rb(), rb(), rb(), 3'd1, EN_NONE, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, OP_STORE, rb(), rb(), rb(), 3'd2, EN_NONE, OP_STORE, 1'b0, 1'b0, 1'b0);
        reset = 1'b0; opcode = OP_STORE; mem_ready = 1'b0; alu_zero = rb(); resume = rb();
        exp_q.push_back({3'd3, 1'b0, EN_MWR, 4'd0, exp_perf()});
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_tick(1'b1, 1'b0, 1'b0);
        step(1'b1, OP_STORE, 1'b1, rb(), rb(), 3'd0, EN_NONE, 4'd0, 1'b0, 1'b0, 1'b0);
        run_instr(OP_LOAD, 1, 1, 1'b0, 0);
        run_instr(OP_STORE, 0, 2, 1'b0, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
